// File: rtl/spi_slave_tester_pkg.sv
// Shared definitions for the SPI slave test-shield tester.
// Symbol-size width, FSM states, SPI mode/bit-order encodings, mask helper.
package spi_slave_tester_pkg;

    localparam int SPI_SYM_SIZE_WIDTH = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } tester_state_t;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_t;

    typedef enum logic {
        SPI_MSB_FIRST = 1'b0,
        SPI_LSB_FIRST = 1'b1
    } spi_bit_order_t;

    // A size of 0, or one that covers the whole bus, selects every bit.
    function automatic logic sym_is_full_width(
        input logic [SPI_SYM_SIZE_WIDTH-1:0] size,
        input int                            width
    );
        return (size == '0) || (int'(size) >= width);
    endfunction

endpackage

// File: rtl/spi_slave_tester_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Count up on inc, stop at the maximum value; reset and clear win.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/spi_slave_tester.sv
// Companion of spi_slave: records per-run statistics from its event
// stream and supplies the dout word (fixed or incrementing) per symbol.
import spi_slave_tester_pkg::*;

module spi_slave_tester #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [5:0]                sym_size,
    input  logic [DATA_BUS_WIDTH-1:0] tx_start_value,
    input  logic                      tx_mode,
    input  logic                      start,
    input  logic                      next,
    input  logic                      stop,
    input  logic [DATA_BUS_WIDTH-1:0] din,
    output logic [DATA_BUS_WIDTH-1:0] dout,
    output logic                      in_transfer,
    output logic [15:0]               transfer_count,
    output logic [COUNT_WIDTH-1:0]    symbol_count,
    output logic [DATA_BUS_WIDTH-1:0] checksum,
    output logic [DATA_BUS_WIDTH-1:0] last_symbol,
    output logic                      protocol_error
);

    localparam logic [DATA_BUS_WIDTH-1:0] D_ONE =
        {{(DATA_BUS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] C_ONE =
        {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    tester_state_t              r_state;
    logic [DATA_BUS_WIDTH-1:0]  r_dout;
    logic [COUNT_WIDTH-1:0]     r_sym_count;
    logic [DATA_BUS_WIDTH-1:0]  r_checksum;
    logic [DATA_BUS_WIDTH-1:0]  r_last;
    logic                       r_error;

    logic [DATA_BUS_WIDTH-1:0]  w_mask;
    logic [DATA_BUS_WIDTH-1:0]  w_din_m;
    logic [DATA_BUS_WIDTH-1:0]  w_start_m;
    logic [DATA_BUS_WIDTH-1:0]  w_dout_next;
    logic                       w_tc_inc;

    // Active-symbol mask: low sym_size bits, or the whole bus.
    always_comb begin
        w_mask = '1;
        if (!sym_is_full_width(sym_size, DATA_BUS_WIDTH)) begin
            w_mask = (D_ONE << sym_size) - D_ONE;
        end
    end

    assign w_din_m     = din & w_mask;
    assign w_start_m   = tx_start_value & w_mask;
    assign w_dout_next = tx_mode ? ((r_dout + D_ONE) & w_mask)
                                 : w_start_m;

    // A stop only completes a transfer when it is not pre-empted by a
    // restart; clear and reset are resolved inside the counter.
    assign w_tc_inc = enable && (r_state == ST_ACTIVE) && !start && stop;

    sat_counter #(
        .WIDTH   (16)
    ) u_transfer_count (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clear),
        .i_inc   (w_tc_inc),
        .o_count (transfer_count)
    );

    // Transfer FSM plus dout register and statistics accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dout      <= '0;
            r_sym_count <= '0;
            r_checksum  <= '0;
            r_last      <= '0;
            r_error     <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_dout      <= tx_start_value;
            r_sym_count <= '0;
            r_checksum  <= '0;
            r_last      <= '0;
            r_error     <= 1'b0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACTIVE;
                        r_dout  <= w_start_m;
                    end
                    // next/stop outside a transfer is illegal, even
                    // when it arrives together with start.
                    if (next || stop) begin
                        r_error <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (start) begin
                        // Restart: flag it, reload dout, stay active.
                        r_error <= 1'b1;
                        r_dout  <= w_start_m;
                    end else begin
                        // next is applied before a same-cycle stop.
                        if (next) begin
                            r_sym_count <= r_sym_count + C_ONE;
                            r_checksum  <= r_checksum + w_din_m;
                            r_last      <= w_din_m;
                            r_dout      <= w_dout_next;
                        end
                        if (stop) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign dout           = r_dout;
    assign in_transfer    = (r_state == ST_ACTIVE);
    assign symbol_count   = r_sym_count;
    assign checksum       = r_checksum;
    assign last_symbol    = r_last;
    assign protocol_error = r_error;

endmodule

// File: tb/tb_spi_slave_tester.sv
// Self-checking bench for spi_slave_tester: directed scenarios plus a
// randomized event stream against a reference model and dout scoreboard.
module tb_spi_slave_tester;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [5:0]  sym_size;
    logic [31:0] tx_start_value;
    logic        tx_mode;
    logic        start;
    logic        next;
    logic        stop;
    logic [31:0] din;
    logic [31:0] dout;
    logic        in_transfer;
    logic [15:0] transfer_count;
    logic [31:0] symbol_count;
    logic [31:0] checksum;
    logic [31:0] last_symbol;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    logic        m_act;
    logic        m_err;
    logic [31:0] m_dout;
    logic [31:0] m_sym;
    logic [31:0] m_chk;
    logic [31:0] m_last;
    logic [15:0] m_tc;

    always #5 clk = ~clk;

    spi_slave_tester #(
        .DATA_BUS_WIDTH (32),
        .COUNT_WIDTH    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .clear          (clear),
        .sym_size       (sym_size),
        .tx_start_value (tx_start_value),
        .tx_mode        (tx_mode),
        .start          (start),
        .next           (next),
        .stop           (stop),
        .din            (din),
        .dout           (dout),
        .in_transfer    (in_transfer),
        .transfer_count (transfer_count),
        .symbol_count   (symbol_count),
        .checksum       (checksum),
        .last_symbol    (last_symbol),
        .protocol_error (protocol_error)
    );

    function automatic logic [31:0] m_mask(input logic [5:0] sz);
        if (sz == 6'd0 || sz >= 6'd32) return 32'hFFFF_FFFF;
        return (32'd1 << sz) - 32'd1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_err = 0; m_dout = 0;
        m_sym = 0; m_chk = 0; m_last = 0; m_tc = 0;
    endtask

    task automatic model_step(input logic s, input logic n,
                              input logic p, input logic [31:0] d);
        logic [31:0] mk;
        mk = m_mask(sym_size);
        if (!enable) return;
        if (!m_act) begin
            if (s) begin
                m_act  = 1;
                m_dout = tx_start_value & mk;
            end
            if (n || p) m_err = 1;
        end else if (s) begin
            m_err  = 1;
            m_dout = tx_start_value & mk;
        end else begin
            if (n) begin
                m_sym  = m_sym + 1;
                m_chk  = m_chk + (d & mk);
                m_last = d & mk;
                m_dout = tx_mode ? ((m_dout + 32'd1) & mk)
                                 : (tx_start_value & mk);
            end
            if (p) begin
                if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
                m_act = 0;
            end
        end
    endtask

    // One clock of slave events; expected dout goes into the scoreboard
    // when driven and is popped once the DUT has registered it.
    task automatic ev(input logic s, input logic n,
                      input logic p, input logic [31:0] d);
        logic [31:0] exp;
        model_step(s, n, p, d);
        exp_q.push_back(m_dout);
        @(negedge clk);
        start = s; next = n; stop = p; din = d;
        @(negedge clk);
        start = 0; next = 0; stop = 0;
        exp = exp_q.pop_front();
        n_checks++;
        if (dout !== exp) begin
            n_errors++;
            $display("FAIL ev_dout: got %h want %h", dout, exp);
        end
        n_checks++;
        if ({in_transfer, protocol_error, symbol_count, checksum,
             last_symbol, transfer_count} !==
            {m_act, m_err, m_sym, m_chk, m_last, m_tc}) begin
            n_errors++;
            $display("FAIL ev_stats: got act%b err%b sym%h chk%h last%h tc%h want act%b err%b sym%h chk%h last%h tc%h",
                     in_transfer, protocol_error, symbol_count, checksum,
                     last_symbol, transfer_count, m_act, m_err, m_sym,
                     m_chk, m_last, m_tc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        model_reset();
        m_dout = tx_start_value;
    endtask

    task automatic test_reset();
        enable = 1; clear = 0; sym_size = 6'd8;
        tx_start_value = 32'h42; tx_mode = 0;
        start = 0; next = 0; stop = 0; din = 0;
        do_reset();
        n_checks++;
        if ({dout, in_transfer, transfer_count, symbol_count, checksum,
             last_symbol, protocol_error} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got dout%h act%b tc%h sym%h chk%h last%h err%b want all 0",
                     dout, in_transfer, transfer_count, symbol_count,
                     checksum, last_symbol, protocol_error);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        sym_size = 6'd8; tx_mode = 0; tx_start_value = 32'h42;
        ev(1, 0, 0, 0);
        n_checks++;
        if (dout !== 32'h42) begin
            n_errors++;
            $display("FAIL fixed_start: got %h want 00000042", dout);
        end
        for (int i = 0; i < 3; i++) begin
            ev(0, 1, 0, 32'hAA);
            n_checks++;
            if (dout !== 32'h42) begin
                n_errors++;
                $display("FAIL fixed_dout%0d: got %h want 00000042", i, dout);
            end
        end
        ev(0, 0, 1, 0);
        n_checks++;
        if (symbol_count !== 32'd3 || checksum !== 32'h1FE ||
            last_symbol !== 32'hAA || transfer_count !== 16'd1 ||
            in_transfer !== 1'b0) begin
            n_errors++;
            $display("FAIL fixed_stats: got sym%0d chk%h last%h tc%0d act%b want 3 1fe aa 1 0",
                     symbol_count, checksum, last_symbol,
                     transfer_count, in_transfer);
        end
    endtask

    task automatic test_incr();
        logic [31:0] seq [4];
        seq[0] = 32'hFE; seq[1] = 32'hFF; seq[2] = 32'h00; seq[3] = 32'h01;
        do_reset();
        sym_size = 6'd8; tx_mode = 1; tx_start_value = 32'hFE;
        ev(1, 0, 0, 0);
        n_checks++;
        if (dout !== seq[0]) begin
            n_errors++;
            $display("FAIL incr_start: got %h want %h", dout, seq[0]);
        end
        for (int i = 1; i < 4; i++) begin
            ev(0, 1, 0, 32'h5);
            n_checks++;
            if (dout !== seq[i]) begin
                n_errors++;
                $display("FAIL incr_step%0d: got %h want %h", i, dout, seq[i]);
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        sym_size = 6'd16; tx_mode = 0; tx_start_value = 32'hABCD_0042;
        ev(1, 0, 0, 0);
        n_checks++;
        if (dout !== 32'h0042) begin
            n_errors++;
            $display("FAIL mask_dout: got %h want 00000042", dout);
        end
        ev(0, 1, 0, 32'hDEAD_1234);
        n_checks++;
        if (last_symbol !== 32'h1234 || checksum !== 32'h1234) begin
            n_errors++;
            $display("FAIL mask_din: got last%h chk%h want 1234 1234",
                     last_symbol, checksum);
        end
    endtask

    task automatic test_error();
        do_reset();
        sym_size = 6'd8; tx_mode = 0; tx_start_value = 32'h42;
        ev(0, 1, 0, 32'h5);
        n_checks++;
        if (protocol_error !== 1'b1 || symbol_count !== 0 ||
            checksum !== 0 || transfer_count !== 0 || in_transfer !== 0) begin
            n_errors++;
            $display("FAIL error_next_idle: got err%b sym%0d chk%h tc%0d act%b want 1 0 0 0 0",
                     protocol_error, symbol_count, checksum,
                     transfer_count, in_transfer);
        end
        do_clear();
        n_checks++;
        if (protocol_error !== 1'b0 || symbol_count !== 0 ||
            checksum !== 0 || transfer_count !== 0 ||
            last_symbol !== 0 || dout !== 32'h42) begin
            n_errors++;
            $display("FAIL error_clear: got err%b sym%0d chk%h tc%0d last%h dout%h want 0 0 0 0 0 42",
                     protocol_error, symbol_count, checksum,
                     transfer_count, last_symbol, dout);
        end
    endtask

    task automatic test_next_stop();
        do_reset();
        sym_size = 6'd8; tx_mode = 1; tx_start_value = 32'h10;
        ev(1, 0, 0, 0);
        ev(0, 1, 1, 32'h7);
        n_checks++;
        if (symbol_count !== 32'd1 || transfer_count !== 16'd1 ||
            in_transfer !== 1'b0 || last_symbol !== 32'h7 ||
            dout !== 32'h11 || protocol_error !== 1'b0) begin
            n_errors++;
            $display("FAIL next_stop: got sym%0d tc%0d act%b last%h dout%h err%b want 1 1 0 7 11 0",
                     symbol_count, transfer_count, in_transfer,
                     last_symbol, dout, protocol_error);
        end
    endtask

    task automatic test_enable();
        do_reset();
        sym_size = 6'd8; tx_mode = 0; tx_start_value = 32'h33;
        ev(1, 0, 0, 0);
        enable = 0;
        ev(0, 1, 0, 32'h9);
        ev(0, 0, 1, 0);
        n_checks++;
        if (in_transfer !== 1'b1 || symbol_count !== 0 ||
            transfer_count !== 0 || protocol_error !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_hold: got act%b sym%0d tc%0d err%b want 1 0 0 0",
                     in_transfer, symbol_count, transfer_count,
                     protocol_error);
        end
        enable = 1;
        ev(0, 0, 1, 0);
        n_checks++;
        if (transfer_count !== 16'd1 || in_transfer !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_resume: got tc%0d act%b want 1 0",
                     transfer_count, in_transfer);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sym_size = 6'd8; tx_mode = 1; tx_start_value = 32'h20;
        ev(1, 0, 0, 0);
        ev(0, 1, 0, 32'h1);
        ev(1, 0, 0, 0);
        n_checks++;
        if (protocol_error !== 1'b1 || transfer_count !== 0 ||
            in_transfer !== 1'b1 || dout !== 32'h20) begin
            n_errors++;
            $display("FAIL restart: got err%b tc%0d act%b dout%h want 1 0 1 20",
                     protocol_error, transfer_count, in_transfer, dout);
        end
        do_reset();
        ev(1, 1, 0, 32'h3);
        n_checks++;
        if (in_transfer !== 1'b1 || protocol_error !== 1'b1 ||
            symbol_count !== 0) begin
            n_errors++;
            $display("FAIL start_next_idle: got act%b err%b sym%0d want 1 1 0",
                     in_transfer, protocol_error, symbol_count);
        end
        ev(0, 0, 1, 0);
        ev(1, 0, 0, 0);
        ev(0, 0, 1, 0);
        n_checks++;
        if (transfer_count !== 16'd2) begin
            n_errors++;
            $display("FAIL back_to_back_tc: got %0d want 2", transfer_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] sizes [9];
        int r;
        sizes[0] = 0;  sizes[1] = 1;  sizes[2] = 7;
        sizes[3] = 8;  sizes[4] = 16; sizes[5] = 31;
        sizes[6] = 32; sizes[7] = 33; sizes[8] = 63;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sym_size = sizes[$urandom_range(0, 8)];
                tx_mode = 1'($urandom_range(0, 1));
                tx_start_value = $urandom;
            end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                do_clear();
                n_checks++;
                if (dout !== m_dout || protocol_error !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rand_clear: got dout%h err%b want %h 0",
                             dout, protocol_error, m_dout);
                end
            end
            r = $urandom_range(0, 9);
            if (r < 2) ev(1, 0, 0, 0);
            else if (r < 7) ev(0, 1, 0, $urandom);
            else if (r < 9) ev(0, 0, 1, 0);
            else ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
        end
        enable = 1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_fixed();
        test_incr();
        test_mask();
        test_error();
        test_next_stop();
        test_enable();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
